intr_arb: RTL
=============

INTR_ARB -- requirements
Module: intr_arb

Interface
REQ-001 Parameter NSRC, default 4: number of interrupt requesters, range 2..8.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 src_req  in  NSRC  level interrupt request, one bit per source.
REQ-005 src_ipl  in  3*NSRC  request level per source; source i occupies bits [3i+2:3i].
REQ-006 src_vector  in  8*NSRC  vector per source; source i occupies bits [8i+7:8i].
REQ-007 src_ack  out  NSRC  one-cycle grant pulse to the serviced source.
REQ-008 cpu_pri  in  3  current processor priority (PSW bits 7:5).
REQ-009 interrupt  out  1  pending interrupt to CPU.
REQ-010 interrupt_ipl  out  8  one-hot level of the pending interrupt.
REQ-011 vector  out  8  vector of the pending interrupt.
REQ-012 ack_ipl  in  8  one-hot CPU acknowledge; bit n acknowledges level n.

Function
REQ-013 States: IDLE, PEND, HOLD; 2-bit state register.
REQ-014 Eligible source: src_req[i]=1 and src_ipl[i] > cpu_pri (unsigned 3-bit compare). Level 0 is never eligible.
REQ-015 IDLE: the winner is the eligible source with the highest src_ipl. Ties go to the lowest index.
REQ-016 IDLE with any eligible source: latch the winner's index, ipl and vector, then go to PEND next cycle.
REQ-017 Latency: request sampled at edge N gives interrupt=1 after edge N+1. There are no combinational paths from src_* to any output.
REQ-018 In PEND:
- interrupt=1.
- interrupt_ipl = one-hot of the latched ipl.
- vector = latched vector.
- All three are held stable until PEND exits.
- Higher-level requests arriving during PEND do not preempt.
REQ-019 PEND, ack_ipl bit equal to the latched ipl is 1:
- Pulse src_ack[winner] for exactly one cycle.
- Go to HOLD.
REQ-020 PEND, ack_ipl bits that do not match the latched ipl are ignored. Multiple set bits count as a match only if the latched-ipl bit is set.
REQ-021 PEND, cancel when src_req[winner]=0 or cpu_pri >= latched ipl:
- Go to IDLE.
- interrupt drops after the next edge.
- No src_ack is issued.
REQ-022 Acknowledge and cancel condition in the same cycle: the acknowledge wins (REQ-019).
REQ-023 HOLD lasts exactly one cycle, then IDLE. No arbitration happens in HOLD; this gives the acknowledged source time to drop its request.
REQ-024 Outside PEND: interrupt=0, interrupt_ipl=8'h00, vector=8'h00.
REQ-025 src_ack is registered and is zero except for the REQ-019 pulse. At most one bit is set at any time.
REQ-026 A source holding src_req after its ack is re-arbitrated from IDLE like any new request.

Reset
REQ-027 reset=1 at an edge forces:
- state=IDLE
- interrupt=0
- interrupt_ipl=0
- vector=0
- src_ack=0
- latched index, ipl and vector cleared
REQ-028 Reset has priority over acknowledge and arbitration. Reset during PEND drops the request without a src_ack.

Verification
REQ-029 Single request: NSRC=4, cpu_pri=0, src_req=0001, ipl0=4, vec0=8'h40.
- interrupt=1, interrupt_ipl=8'h10, vector=8'h40 one cycle later.
- ack_ipl=8'h10: src_ack=0001 for one cycle, then HOLD, then IDLE.
REQ-030 Priority and tie:
- src_req=1110, ipl1=5, ipl2=6, ipl3=6, vec2=8'h60: vector=8'h60, interrupt_ipl=8'h40.
- After ack and release of source 2: vec3 is presented, interrupt_ipl=8'h40.
REQ-031 Masking: cpu_pri=5, only ipl=5 requesting: interrupt stays 0 for 10 cycles. Lowering cpu_pri to 4 gives interrupt=1 one cycle later.
REQ-032 Cancel:
- In PEND at ipl 4, raise cpu_pri to 4: interrupt=0 after one cycle, src_ack never set.
- Repeat, but drop src_req instead: same response.
REQ-033 Wrong and simultaneous acks:
- ack_ipl=8'h20 while pending at ipl 4: ignored, outputs unchanged.
- ack_ipl=8'h10 in the same cycle src_req drops: src_ack is still pulsed.
REQ-034 Reset mid-PEND: reset asserted while interrupt=1 gives all outputs zero after the edge, no src_ack, and normal arbitration resumes after reset deasserts.

Source files
------------

// File: rtl/intr_arb.sv
// ---------------------------------------------------------------------------
// intr_arb -- prioritised interrupt arbiter for a single CPU.
//
// Picks the highest-level eligible requester, presents its level (one-hot) and
// vector to the CPU and holds them until the CPU acknowledges at that level or
// the request is cancelled. After an acknowledge, a one-cycle HOLD gives the
// serviced source time to drop its request before arbitration resumes.
//
// Every output is a flop. On the edge that samples a winning request, the
// arbiter moves IDLE->PEND and loads the outputs. There is no combinational
// path from any src_* input to an output.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   src_req        level request, one bit per source
//   src_ipl        3-bit level per source, source i at [3i+2:3i]
//   src_vector     8-bit vector per source, source i at [8i+7:8i]
//   src_ack        one-cycle grant pulse to the serviced source
//   cpu_pri        current processor priority
//   interrupt      pending interrupt to the CPU
//   interrupt_ipl  one-hot level of the pending interrupt
//   vector         vector of the pending interrupt
//   ack_ipl        one-hot CPU acknowledge, bit n acknowledges level n
// ---------------------------------------------------------------------------
module intr_arb #(
  parameter int NSRC = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NSRC-1:0]     src_req,
  input  logic [3*NSRC-1:0]   src_ipl,
  input  logic [8*NSRC-1:0]   src_vector,
  output logic [NSRC-1:0]     src_ack,
  input  logic [2:0]          cpu_pri,
  output logic                interrupt,
  output logic [7:0]          interrupt_ipl,
  output logic [7:0]          vector,
  input  logic [7:0]          ack_ipl
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e          state_r;
  state_e          state_next_s;

  // Latched winner; a 3-bit index covers the full 2..8 source range.
  logic [2:0]      win_idx_r;
  logic [2:0]      win_ipl_r;
  logic [7:0]      win_vec_r;

  // Combinational arbitration result.
  logic [2:0]      best_idx_s;
  logic [2:0]      best_ipl_s;
  logic [7:0]      best_vec_s;

  logic            req_win_s;
  logic            ack_hit_s;
  logic            cancel_s;
  logic            latch_s;

  logic [NSRC-1:0] ack_next_s;
  logic            int_next_s;
  logic [7:0]      ipl_next_s;
  logic [7:0]      vec_next_s;

  // One-hot encoding of a 3-bit level.
  function automatic logic [7:0] ipl_onehot(input logic [2:0] ipl);
    return 8'd1 << ipl;
  endfunction

  // Highest-level eligible source. Scanning upward with a strict '>' keeps
  // the lowest index on ties. An eligible level is always above cpu_pri, so it
  // is at least 1; best_ipl_s == 0 therefore means no source is eligible.
  always_comb begin
    best_idx_s = 3'd0;
    best_ipl_s = 3'd0;
    best_vec_s = 8'd0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_req[i] && (src_ipl[3*i +: 3] > cpu_pri) &&
          (src_ipl[3*i +: 3] > best_ipl_s)) begin
        best_idx_s = 3'(i);
        best_ipl_s = src_ipl[3*i +: 3];
        best_vec_s = src_vector[8*i +: 8];
      end else begin
        best_idx_s = best_idx_s;
      end
    end
  end

  // Current request level of the latched winner, and the one-hot ack mask
  // aimed at it.
  always_comb begin
    req_win_s = 1'b0;
    ack_next_s = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (win_idx_r == 3'(i)) begin
        req_win_s     = src_req[i];
        ack_next_s[i] = 1'b1;
      end else begin
        ack_next_s[i] = 1'b0;
      end
    end
  end

  // Only the ack bit at the latched level counts; other bits are ignored.
  assign ack_hit_s = ack_ipl[win_ipl_r];
  assign cancel_s  = !req_win_s || (cpu_pri >= win_ipl_r);

  // Next-state logic. In PEND, acknowledge is tested before cancel, so an ack
  // wins when both happen in the same cycle.
  always_comb begin
    state_next_s = state_r;
    latch_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (best_ipl_s != 3'd0) begin
          state_next_s = PEND;
          latch_s      = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      PEND: begin
        if (ack_hit_s) begin
          state_next_s = HOLD;
        end else if (cancel_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = PEND;
        end
      end
      HOLD: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs. The outputs show the winner only
  // while the next state is PEND.
  always_comb begin
    int_next_s = (state_next_s == PEND);
    ipl_next_s = 8'd0;
    vec_next_s = 8'd0;
    if (latch_s) begin
      ipl_next_s = ipl_onehot(best_ipl_s);
      vec_next_s = best_vec_s;
    end else if (state_next_s == PEND) begin
      ipl_next_s = ipl_onehot(win_ipl_r);
      vec_next_s = win_vec_r;
    end else begin
      ipl_next_s = 8'd0;
      vec_next_s = 8'd0;
    end
  end

  // State register, winner latch and registered outputs; reset overrides all.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      win_idx_r     <= 3'd0;
      win_ipl_r     <= 3'd0;
      win_vec_r     <= 8'd0;
      src_ack       <= '0;
      interrupt     <= 1'b0;
      interrupt_ipl <= 8'd0;
      vector        <= 8'd0;
    end else begin
      state_r <= state_next_s;
      if (latch_s) begin
        win_idx_r <= best_idx_s;
        win_ipl_r <= best_ipl_s;
        win_vec_r <= best_vec_s;
      end
      src_ack       <= ((state_r == PEND) && ack_hit_s) ? ack_next_s : '0;
      interrupt     <= int_next_s;
      interrupt_ipl <= ipl_next_s;
      vector        <= vec_next_s;
    end
  end

endmodule
